f11_bus_master: RTL and testbench
=================================

Name: f11_bus_master

Overview:
- Bus-cycle sequencer on the far side of the DC304 MMU translated-address interface.
- Takes the F11 address microcycle: 16-bit A/D plus high address lines 21:16, the I/O-page select, the MMU register reply and the translation-abort flag.
- Runs one Wishbone master cycle per CPU bus transaction and returns read data, completion, or an abort/timeout/odd-address status to the CPU microsequencer.
- MMU-internal register accesses and aborted translations never reach the external bus.

Parameters:
TMO_CNT, 63, cycles stb may stay asserted without ack before bus timeout (6-bit counter; valid range 1..63)
ODD_CHK, 1, 1 = word access to odd address is rejected without a bus cycle

Ports:
pin_clk     in   1   main clock
pin_rst_n   in   1   asynchronous active-low reset
pin_astb    in   1   address strobe, one-cycle pulse; pin_adi/pin_a valid in same cycle
pin_dstb    in   1   data strobe, one-cycle pulse; pin_wr/pin_byte/pin_adi (write data) valid in same cycle
pin_adi     in   16  multiplexed address/data from CPU/MMU
pin_a       in   6   translated high address 21:16
pin_bso     in   1   I/O-page select from MMU, valid cycle after pin_astb
pin_ra      in   1   MMU register access reply, valid cycle after pin_astb
pin_de      in   1   MMU translation error, valid cycle after pin_astb
pin_wr      in   1   1 = write (qualified by pin_dstb)
pin_byte    in   1   1 = byte access (qualified by pin_dstb)
pin_rdy     out  1   one-cycle completion pulse
pin_dout    out  16  read data, held until next completion
pin_abort   out  1   one-cycle pulse, MMU abort (pin_de)
pin_berr    out  1   one-cycle pulse, bus timeout
pin_oddr    out  1   one-cycle pulse, odd-address word access
wb_adr_o    out  22  byte address, bit 0 forced 0
wb_dat_o    out  16  write data
wb_dat_i    in   16  read data
wb_cyc_o    out  1   cycle
wb_stb_o    out  1   strobe
wb_we_o     out  1   write enable
wb_sel_o    out  2   byte lanes
wb_iop_o    out  1   I/O-page qualifier (latched pin_bso)
wb_ack_i    in   1   acknowledge

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0, including pin_dout, wb_adr_o and wb_dat_o. Cyc/stb drop immediately on reset, even mid-cycle.
- States: IDLE, CHK, WDAT, INT, BUS, DONE.
- IDLE: on pin_astb, latch adr = {pin_a, pin_adi} and go to CHK.
- CHK (exactly 1 cycle after astb): sample pin_de, pin_ra, pin_bso; latch iop = pin_bso. Priority:
  - pin_de: pulse pin_abort, go to IDLE.
  - pin_ra: go to INT.
  - otherwise: go to WDAT.
- INT: wait pin_dstb, then pulse pin_rdy next cycle and go to IDLE. No Wishbone activity. pin_dout is unchanged; the MMU drives read data itself.
- WDAT: wait pin_dstb; latch we = pin_wr, byte = pin_byte, wdat = pin_adi.
  - If ODD_CHK = 1, byte = 0 and adr[0] = 1: pulse pin_oddr, go to IDLE.
  - Otherwise go to BUS.
- BUS: wb_cyc_o = wb_stb_o = 1.
  - wb_adr_o = {adr[21:1], 0}; wb_we_o = we; wb_iop_o = iop.
  - wb_sel_o = 2'b11 for word, 2'b01 for byte at even address, 2'b10 for byte at odd address.
  - Byte write: wb_dat_o = {wdat[7:0], wdat[7:0]}; word write: wdat.
  - Timeout counter clears on entry to BUS and increments each BUS cycle without ack.
  - On wb_ack_i: drop cyc/stb next edge. For a read, latch pin_dout = wb_dat_i; byte at odd address is zero-extended from wb_dat_i[15:8], byte at even address from [7:0]. Go to DONE.
  - If counter reaches TMO_CNT with no ack: drop cyc/stb, pulse pin_berr, go to IDLE. Ack in that same cycle wins over timeout.
- DONE: pulse pin_rdy for 1 cycle, go to IDLE.
- Latency: a zero-wait-state slave (ack in the first BUS cycle) gives pin_rdy 2 cycles after the BUS-entry edge.
- pin_astb in any state other than IDLE is ignored and the current transaction continues. pin_dstb in IDLE or CHK is ignored.
- Mutual exclusion: pin_rdy, pin_abort, pin_berr and pin_oddr are never asserted together. Exactly one of them fires per accepted astb, unless reset intervenes.
- Address wrap: none; the full 22-bit address passes through.

Test Plan:
1. Word read: astb with adr 0o17777776 (pin_a=6'o77, adi=0o177776), bso=1, ra=0, de=0; dstb wr=0; slave acks on 3rd BUS cycle with 0o123456 -> wb_sel 11, wb_iop_o=1, pin_dout=0o123456, a single pin_rdy pulse.
2. Byte write to odd address 0o001001, data 0o000252 -> wb_sel 10, wb_dat_o=0o125252, wb_we_o=1, pin_rdy after ack.
3. Translation abort: pin_de=1 in CHK -> pin_abort pulse, no wb_cyc_o ever asserted, back in IDLE; next astb accepted.
4. MMU register access: pin_ra=1 for adr 0o17777572, then dstb -> pin_rdy one cycle after dstb, wb_cyc_o stays 0, pin_dout unchanged.
5. Timeout, TMO_CNT=63, no ack -> cyc/stb held 63 cycles, then pin_berr pulse and cyc low. Repeat with ack in cycle 63 -> pin_rdy, no pin_berr.
6. Odd word access adr 0o000003 -> pin_oddr pulse, no bus cycle. Assert pin_rst_n=0 mid-BUS -> cyc/stb/we low asynchronously, state IDLE.

Source files
------------

// File: rtl/f11_bus_master.sv
// F11 bus-cycle sequencer: turns one translated CPU bus transaction from the
// DC304 MMU interface into a single Wishbone master cycle and reports its outcome.
module f11_bus_master #(
  parameter int unsigned TMO_CNT = 63,   // 1..63 cycles of stb without ack
  parameter bit          ODD_CHK = 1'b1
) (
  input  logic        pin_clk,
  input  logic        pin_rst_n,
  input  logic        pin_astb,
  input  logic        pin_dstb,
  input  logic [15:0] pin_adi,
  input  logic [5:0]  pin_a,
  input  logic        pin_bso,
  input  logic        pin_ra,
  input  logic        pin_de,
  input  logic        pin_wr,
  input  logic        pin_byte,
  output logic        pin_rdy,
  output logic [15:0] pin_dout,
  output logic        pin_abort,
  output logic        pin_berr,
  output logic        pin_oddr,
  output logic [21:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        wb_iop_o,
  input  logic        wb_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHK, S_WDAT, S_INT, S_BUS, S_DONE
  } state_t;

  localparam logic [5:0] TMO_LAST = 6'(TMO_CNT - 1);

  state_t      state, state_d;
  logic [21:0] adr_q;
  logic        iop_q;
  logic        byte_q;
  logic [5:0]  tmo_q;

  logic rdy_d, abort_d, berr_d, oddr_d;
  logic bus_start, bus_end, rd_latch;
  logic odd_word;

  assign odd_word = ODD_CHK && !pin_byte && adr_q[0];

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state;
    rdy_d     = 1'b0;
    abort_d   = 1'b0;
    berr_d    = 1'b0;
    oddr_d    = 1'b0;
    bus_start = 1'b0;
    bus_end   = 1'b0;
    rd_latch  = 1'b0;
    case (state)
      S_IDLE: if (pin_astb) state_d = S_CHK;
      S_CHK: begin
        if (pin_de) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else if (pin_ra) begin
          state_d = S_INT;
        end else begin
          state_d = S_WDAT;
        end
      end
      S_INT: begin
        if (pin_dstb) begin
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WDAT: begin
        if (pin_dstb) begin
          if (odd_word) begin
            oddr_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            bus_start = 1'b1;
            state_d   = S_BUS;
          end
        end
      end
      S_BUS: begin
        // An ack arriving in the final allowed cycle still completes normally.
        if (wb_ack_i) begin
          bus_end  = 1'b1;
          rd_latch = !wb_we_o;
          state_d  = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          bus_end = 1'b1;
          berr_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge pin_clk or negedge pin_rst_n) begin
    if (!pin_rst_n) state <= S_IDLE;
    else            state <= state_d;
  end

  always_ff @(posedge pin_clk or negedge pin_rst_n) begin
    if (!pin_rst_n) begin
      adr_q     <= '0;
      iop_q     <= 1'b0;
      byte_q    <= 1'b0;
      tmo_q     <= '0;
      pin_rdy   <= 1'b0;
      pin_abort <= 1'b0;
      pin_berr  <= 1'b0;
      pin_oddr  <= 1'b0;
      pin_dout  <= '0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= '0;
      wb_iop_o  <= 1'b0;
    end else begin
      pin_rdy   <= rdy_d;
      pin_abort <= abort_d;
      pin_berr  <= berr_d;
      pin_oddr  <= oddr_d;

      if (state == S_IDLE && pin_astb) adr_q <= {pin_a, pin_adi};
      if (state == S_CHK) iop_q <= pin_bso;

      if (bus_start) begin
        byte_q   <= pin_byte;
        tmo_q    <= '0;
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o  <= pin_wr;
        wb_iop_o <= iop_q;
        wb_adr_o <= {adr_q[21:1], 1'b0};
        wb_sel_o <= pin_byte ? (adr_q[0] ? 2'b10 : 2'b01) : 2'b11;
        wb_dat_o <= pin_byte ? {pin_adi[7:0], pin_adi[7:0]} : pin_adi;
      end else if (state == S_BUS && !wb_ack_i) begin
        tmo_q <= tmo_q + 6'd1;
      end

      if (bus_end) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        wb_we_o  <= 1'b0;
        wb_iop_o <= 1'b0;
      end

      // Byte reads come back zero-extended from the lane selected by address bit 0.
      if (rd_latch) begin
        if (!byte_q)      pin_dout <= wb_dat_i;
        else if (adr_q[0]) pin_dout <= {8'h00, wb_dat_i[15:8]};
        else              pin_dout <= {8'h00, wb_dat_i[7:0]};
      end
    end
  end

endmodule

// File: tb/tb_f11_bus_master.sv
// Directed bench for f11_bus_master: each transaction type, timeout boundary,
// odd-address rejection and asynchronous reset, checked against hand-computed values.
module tb_f11_bus_master;

  logic        pin_clk = 1'b0;
  logic        pin_rst_n;
  logic        pin_astb, pin_dstb;
  logic [15:0] pin_adi;
  logic [5:0]  pin_a;
  logic        pin_bso, pin_ra, pin_de, pin_wr, pin_byte;
  logic        pin_rdy, pin_abort, pin_berr, pin_oddr;
  logic [15:0] pin_dout;
  logic [21:0] wb_adr_o;
  logic [15:0] wb_dat_o, wb_dat_i;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_iop_o, wb_ack_i;
  logic [1:0]  wb_sel_o;

  int n_vec = 0;
  int n_bad = 0;
  int rdy_cnt = 0, abort_cnt = 0, berr_cnt = 0, oddr_cnt = 0;
  int cyc_cnt = 0, multi_cnt = 0;

  f11_bus_master #(.TMO_CNT(63), .ODD_CHK(1'b1)) dut (
    .pin_clk(pin_clk), .pin_rst_n(pin_rst_n),
    .pin_astb(pin_astb), .pin_dstb(pin_dstb), .pin_adi(pin_adi), .pin_a(pin_a),
    .pin_bso(pin_bso), .pin_ra(pin_ra), .pin_de(pin_de),
    .pin_wr(pin_wr), .pin_byte(pin_byte),
    .pin_rdy(pin_rdy), .pin_dout(pin_dout), .pin_abort(pin_abort),
    .pin_berr(pin_berr), .pin_oddr(pin_oddr),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_iop_o(wb_iop_o), .wb_ack_i(wb_ack_i)
  );

  always #5 pin_clk = ~pin_clk;

  always @(negedge pin_clk) begin
    if (pin_rst_n) begin
      rdy_cnt   <= rdy_cnt + int'(pin_rdy);
      abort_cnt <= abort_cnt + int'(pin_abort);
      berr_cnt  <= berr_cnt + int'(pin_berr);
      oddr_cnt  <= oddr_cnt + int'(pin_oddr);
      cyc_cnt   <= cyc_cnt + int'(wb_cyc_o);
      if ((int'(pin_rdy) + int'(pin_abort) + int'(pin_berr) + int'(pin_oddr)) > 1)
        multi_cnt <= multi_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pin_clk);
    #1;
  endtask

  task automatic addr_phase(input logic [5:0] a, input logic [15:0] adi,
                            input logic bso, input logic ra, input logic de);
    pin_astb = 1'b1; pin_a = a; pin_adi = adi;
    step();
    pin_astb = 1'b0; pin_bso = bso; pin_ra = ra; pin_de = de;
    step();
    pin_bso = 1'b0; pin_ra = 1'b0; pin_de = 1'b0;
  endtask

  task automatic data_phase(input logic wr, input logic byt, input logic [15:0] dat);
    pin_dstb = 1'b1; pin_wr = wr; pin_byte = byt; pin_adi = dat;
    step();
    pin_dstb = 1'b0; pin_wr = 1'b0; pin_byte = 1'b0;
  endtask

  // Slave acks in the current BUS cycle; checks cyc drop and the delayed rdy pulse.
  task automatic ack_now(input string tag, input logic [15:0] rdata);
    wb_ack_i = 1'b1; wb_dat_i = rdata;
    step();
    wb_ack_i = 1'b0;
    check({tag, "_cyc_drop"}, wb_cyc_o, 1'b0);
    check({tag, "_rdy_early"}, pin_rdy, 1'b0);
    step();
    check({tag, "_rdy"}, pin_rdy, 1'b1);
    step();
    check({tag, "_rdy_once"}, pin_rdy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    pin_rst_n = 1'b0;
    pin_astb = 0; pin_dstb = 0; pin_adi = '0; pin_a = '0;
    pin_bso = 0; pin_ra = 0; pin_de = 0; pin_wr = 0; pin_byte = 0;
    wb_dat_i = '0; wb_ack_i = 1'b0;
    step(); step();
    check("rst_ctl", {wb_cyc_o, wb_stb_o, wb_we_o, wb_iop_o, wb_sel_o,
                      pin_rdy, pin_abort, pin_berr, pin_oddr}, '0);
    check("rst_adr", wb_adr_o, '0);
    check("rst_dat", {wb_dat_o, pin_dout}, '0);
    pin_rst_n = 1'b1;
    step();

    // 1: word read from the top of the I/O page, ack on the third BUS cycle
    addr_phase(6'o77, 16'o177776, 1'b1, 1'b0, 1'b0);
    data_phase(1'b0, 1'b0, 16'o0);
    check("t1_cyc", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b110);
    check("t1_sel", wb_sel_o, 2'b11);
    check("t1_iop", wb_iop_o, 1'b1);
    check("t1_adr", wb_adr_o, 22'o17777776);
    step(); step();
    check("t1_wait", wb_cyc_o, 1'b1);
    ack_now("t1", 16'o123456);
    check("t1_dout", pin_dout, 16'o123456);

    // 2: byte write to an odd address, zero-wait slave
    addr_phase(6'o00, 16'o001001, 1'b0, 1'b0, 1'b0);
    data_phase(1'b1, 1'b1, 16'o000252);
    check("t2_sel", wb_sel_o, 2'b10);
    check("t2_dat", wb_dat_o, 16'o125252);
    check("t2_we", wb_we_o, 1'b1);
    check("t2_adr", wb_adr_o, 22'o001000);
    check("t2_iop", wb_iop_o, 1'b0);
    ack_now("t2", 16'hFFFF);
    check("t2_we_drop", wb_we_o, 1'b0);
    check("t2_dout_kept", pin_dout, 16'o123456);

    // 3: translation abort never reaches the bus
    base = cyc_cnt;
    addr_phase(6'o00, 16'o000100, 1'b0, 1'b0, 1'b1);
    check("t3_abort", pin_abort, 1'b1);
    step();
    check("t3_abort_once", pin_abort, 1'b0);
    check("t3_no_cyc", cyc_cnt - base, 0);

    // 4: MMU register access, accepted right after the abort
    addr_phase(6'o77, 16'o177572, 1'b1, 1'b1, 1'b0);
    step(); step();
    check("t4_wait", pin_rdy, 1'b0);
    data_phase(1'b0, 1'b0, 16'o0);
    check("t4_rdy", pin_rdy, 1'b1);
    step();
    check("t4_rdy_once", pin_rdy, 1'b0);
    check("t4_no_cyc", cyc_cnt - base, 0);
    check("t4_dout", pin_dout, 16'o123456);

    // 5a: timeout with no ack; a stray astb mid-cycle is ignored
    addr_phase(6'o00, 16'o000200, 1'b0, 1'b0, 1'b0);
    data_phase(1'b0, 1'b0, 16'o0);
    n = 1;
    while (n < 200) begin
      if (n == 5) begin pin_astb = 1'b1; pin_a = 6'o12; pin_adi = 16'o000777; end
      step();
      if (n == 5) pin_astb = 1'b0;
      if (n == 6) check("t5_astb_ignored", wb_adr_o, 22'o000200);
      if (!wb_cyc_o) break;
      n++;
    end
    check("t5_tmo_len", n, 63);
    check("t5_berr", pin_berr, 1'b1);
    check("t5_stb_drop", wb_stb_o, 1'b0);
    step();
    check("t5_berr_once", pin_berr, 1'b0);

    // 5b: ack in the 63rd cycle beats the timeout
    addr_phase(6'o00, 16'o000200, 1'b0, 1'b0, 1'b0);
    data_phase(1'b0, 1'b0, 16'o0);
    repeat (62) step();
    check("t5b_still_cyc", wb_cyc_o, 1'b1);
    ack_now("t5b", 16'o000777);
    check("t5b_dout", pin_dout, 16'o000777);

    // byte reads: lane selection and zero extension
    addr_phase(6'o00, 16'o002001, 1'b0, 1'b0, 1'b0);
    data_phase(1'b0, 1'b1, 16'o0);
    check("br_odd_sel", wb_sel_o, 2'b10);
    ack_now("br_odd", 16'hA55A);
    check("br_odd_dout", pin_dout, 16'h00A5);
    addr_phase(6'o00, 16'o002000, 1'b0, 1'b0, 1'b0);
    data_phase(1'b0, 1'b1, 16'o0);
    check("br_even_sel", wb_sel_o, 2'b01);
    ack_now("br_even", 16'hA55A);
    check("br_even_dout", pin_dout, 16'h005A);

    // 6: odd word access rejected without a bus cycle
    base = cyc_cnt;
    addr_phase(6'o00, 16'o000003, 1'b0, 1'b0, 1'b0);
    data_phase(1'b0, 1'b0, 16'o0);
    check("t6_oddr", pin_oddr, 1'b1);
    check("t6_no_cyc", wb_cyc_o, 1'b0);
    step();
    check("t6_oddr_once", pin_oddr, 1'b0);
    check("t6_no_cyc_cnt", cyc_cnt - base, 0);

    // 6b: asynchronous reset in the middle of a write cycle
    addr_phase(6'o00, 16'o000004, 1'b0, 1'b0, 1'b0);
    data_phase(1'b1, 1'b0, 16'o001234);
    check("t6b_cyc_before", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b111);
    #2 pin_rst_n = 1'b0;
    #1;
    check("t6b_async_drop", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
    check("t6b_regs", {wb_adr_o, pin_dout}, '0);
    step();
    pin_rst_n = 1'b1;
    step();
    check("t6b_idle", wb_cyc_o, 1'b0);

    // post-reset transaction proves the FSM is back in IDLE
    addr_phase(6'o01, 16'o000010, 1'b0, 1'b0, 1'b0);
    data_phase(1'b0, 1'b0, 16'o0);
    check("pr_adr", wb_adr_o, 22'o00200010);
    ack_now("pr", 16'o070707);
    check("pr_dout", pin_dout, 16'o070707);

    step();
    check("sum_rdy", rdy_cnt, 7);
    check("sum_abort", abort_cnt, 1);
    check("sum_berr", berr_cnt, 1);
    check("sum_oddr", oddr_cnt, 1);
    check("sum_exclusive", multi_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
